register_file_multi_port_rw: RTL and testbench

Flop-based register file with `N_WRITE` independent write ports and `N_READ` registered-address read ports.
- Each write port has per-byte write enables, and concurrent writes are resolved by fixed port priority per byte.
- All storage resets synchronously to zero.
- An optional hard-wired zero word (word 0) is provided.
- It is the multi-writer successor to the single-write gated-clock register file. Multi-issue cores and accelerators use it where more than one unit retires results in the same cycle.

---
 rtl/register_file_multi_port_rw.sv | 100 ++++++++++
 tb/tb_register_file_multi_port_rw.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_multi_port_rw.sv
// -----------------------------------------------------------------------------
// register_file_multi_port_rw
//
// Flop-based register file with N_WRITE independent byte-enabled write ports
// and N_READ read ports whose addresses are captured in registers.  Read data
// is driven combinationally from the registered address, so a held address
// keeps tracking later writes.  Concurrent writes to the same byte of the same
// word are resolved in favour of the highest-indexed port.  Optional
// hard-wired zero word 0 (ZERO_REG = 1).
//
// Ports:
//   clk          sole clock, rising edge
//   rst_n        synchronous active-low reset (clears words and read addresses)
//   ReadEnable   [N_READ]                 per-port read address capture enable
//   ReadAddr     [N_READ][ADDR_WIDTH]     read addresses
//   ReadData     [N_READ][DATA_WIDTH]     read data (from registered address)
//   WriteEnable  [N_WRITE]                per-port write enable
//   WriteAddr    [N_WRITE][ADDR_WIDTH]    write addresses
//   WriteBE      [N_WRITE][NUM_BYTES]     per-port byte enables
//   WriteData    [N_WRITE][DATA_WIDTH]    write data
// -----------------------------------------------------------------------------
module register_file_multi_port_rw #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int N_READ     = 2,
  parameter int N_WRITE    = 2,
  parameter int ZERO_REG   = 0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_READ-1:0]                     ReadEnable,
  input  logic [N_READ-1:0][ADDR_WIDTH-1:0]     ReadAddr,
  output logic [N_READ-1:0][DATA_WIDTH-1:0]     ReadData,
  input  logic [N_WRITE-1:0]                    WriteEnable,
  input  logic [N_WRITE-1:0][ADDR_WIDTH-1:0]    WriteAddr,
  input  logic [N_WRITE-1:0][DATA_WIDTH/8-1:0]  WriteBE,
  input  logic [N_WRITE-1:0][DATA_WIDTH-1:0]    WriteData
);

  localparam int NUM_WORDS = 2 ** ADDR_WIDTH;
  localparam int NUM_BYTES = DATA_WIDTH / 8;

  logic [NUM_WORDS-1:0][NUM_BYTES-1:0][7:0] mem_r;
  logic [N_READ-1:0][ADDR_WIDTH-1:0]        raddr_r;
  logic [NUM_WORDS-1:0][NUM_BYTES-1:0]      byte_we_s;
  logic [NUM_WORDS-1:0][NUM_BYTES-1:0][7:0] byte_wdata_s;

  // Per word/byte write decode; ports scanned in ascending order so the
  // highest-indexed hitting port overrides lower ones byte by byte.
  always_comb begin
    byte_we_s    = '0;
    byte_wdata_s = '0;
    for (int w = 0; w < N_WRITE; w++) begin
      for (int a = 0; a < NUM_WORDS; a++) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          logic hit_s;
          hit_s = WriteEnable[w] && (WriteAddr[w] == ADDR_WIDTH'(a)) && WriteBE[w][b]
                  && !((ZERO_REG != 0) && (a == 0));
          byte_we_s[a][b]    = byte_we_s[a][b] | hit_s;
          byte_wdata_s[a][b] = hit_s ? WriteData[w][8*b +: 8] : byte_wdata_s[a][b];
        end
      end
    end
  end

  // Storage and read address registers; reset overrides every enable.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_r   <= '0;
      raddr_r <= '0;
    end else begin
      for (int a = 0; a < NUM_WORDS; a++) begin
        for (int b = 0; b < NUM_BYTES; b++) begin
          if (byte_we_s[a][b]) begin
            mem_r[a][b] <= byte_wdata_s[a][b];
          end
        end
      end
      for (int r = 0; r < N_READ; r++) begin
        if (ReadEnable[r]) begin
          raddr_r[r] <= ReadAddr[r];
        end
      end
    end
  end

  // Read mux from the registered address only; word 0 forced to zero when
  // the hard-wired zero word is enabled.
  always_comb begin
    ReadData = '0;
    for (int r = 0; r < N_READ; r++) begin
      if ((ZERO_REG != 0) && (raddr_r[r] == {ADDR_WIDTH{1'b0}})) begin
        ReadData[r] = {DATA_WIDTH{1'b0}};
      end else begin
        ReadData[r] = mem_r[raddr_r[r]];
      end
    end
  end

endmodule

// File: tb/tb_register_file_multi_port_rw.sv
module tb_register_file_multi_port_rw;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int NB = DW / 8;

  logic                    clk;
  logic                    rst_n;
  logic [NR-1:0]           ReadEnable;
  logic [NR-1:0][AW-1:0]   ReadAddr;
  logic [NR-1:0][DW-1:0]   ReadData;
  logic [NR-1:0][DW-1:0]   zReadData;
  logic [NW-1:0]           WriteEnable;
  logic [NW-1:0][AW-1:0]   WriteAddr;
  logic [NW-1:0][NB-1:0]   WriteBE;
  logic [NW-1:0][DW-1:0]   WriteData;

  typedef struct {
    logic [DW-1:0] exp;
    int            port;
    bit            z;
  } sb_t;

  sb_t sb[$];
  int  n_cmp;
  int  n_bad;

  register_file_multi_port_rw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR),
                                .N_WRITE(NW), .ZERO_REG(0)) dut (
    .clk(clk), .rst_n(rst_n), .ReadEnable(ReadEnable), .ReadAddr(ReadAddr),
    .ReadData(ReadData), .WriteEnable(WriteEnable), .WriteAddr(WriteAddr),
    .WriteBE(WriteBE), .WriteData(WriteData));

  register_file_multi_port_rw #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .N_READ(NR),
                                .N_WRITE(NW), .ZERO_REG(1)) dut_z (
    .clk(clk), .rst_n(rst_n), .ReadEnable(ReadEnable), .ReadAddr(ReadAddr),
    .ReadData(zReadData), .WriteEnable(WriteEnable), .WriteAddr(WriteAddr),
    .WriteBE(WriteBE), .WriteData(WriteData));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    ReadEnable  = '0;
    ReadAddr    = '0;
    WriteEnable = '0;
    WriteAddr   = '0;
    WriteBE     = '0;
    WriteData   = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [DW-1:0] act;
    sb_t e;
    // preload every word with 0xDEADBEEF, two words per edge
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      idle();
      WriteEnable = 2'b11;
      WriteAddr[0] = AW'(2 * i);
      WriteAddr[1] = AW'(2 * i + 1);
      WriteBE = '1;
      WriteData[0] = 32'hDEADBEEF;
      WriteData[1] = 32'hDEADBEEF;
    end
    // one-edge reset pulse with a competing write and read capture (both lost)
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    WriteEnable[0] = 1'b1;
    WriteAddr[0] = 5'd2;
    WriteBE[0] = 4'hF;
    WriteData[0] = 32'h77777777;
    ReadEnable = 2'b11;
    ReadAddr[0] = 5'd2;
    ReadAddr[1] = 5'd3;
    sb.push_back('{exp: 32'h0, port: 0, z: 1'b0});
    sb.push_back('{exp: 32'h0, port: 1, z: 1'b0});
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.z ? zReadData[e.port] : ReadData[e.port];
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL reset_first_cycle port%0d: got %h expected %h", e.port, act, e.exp);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      ReadEnable = 2'b11;
      ReadAddr[0] = AW'(i);
      ReadAddr[1] = AW'(31 - i);
      sb.push_back('{exp: 32'h0, port: 0, z: 1'b0});
      sb.push_back('{exp: 32'h0, port: 1, z: 1'b0});
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = e.z ? zReadData[e.port] : ReadData[e.port];
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL reset_clear word_idx%0d port%0d: got %h expected %h", i, e.port, act, e.exp);
        end
      end
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_write_first();
    logic [DW-1:0] act;
    sb_t e;
    @(negedge clk);
    idle();
    WriteEnable[0] = 1'b1;
    WriteAddr[0] = 5'd7;
    WriteBE[0] = 4'hF;
    WriteData[0] = 32'h12345678;
    ReadEnable[1] = 1'b1;
    ReadAddr[1] = 5'd7;
    sb.push_back('{exp: 32'h12345678, port: 1, z: 1'b0});
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.z ? zReadData[e.port] : ReadData[e.port];
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL write_first port%0d: got %h expected %h", e.port, act, e.exp);
      end
    end
  endtask

  task automatic test_conflict();
    logic [DW-1:0] act;
    sb_t e;
    @(negedge clk);
    idle();
    WriteEnable = 2'b11;
    WriteAddr[0] = 5'd3;
    WriteAddr[1] = 5'd3;
    WriteBE[0] = 4'hF;
    WriteBE[1] = 4'h3;
    WriteData[0] = 32'hAAAAAAAA;
    WriteData[1] = 32'h55555555;
    ReadEnable = 2'b11;
    ReadAddr[0] = 5'd3;
    ReadAddr[1] = 5'd3;
    sb.push_back('{exp: 32'hAAAA5555, port: 0, z: 1'b0});
    sb.push_back('{exp: 32'hAAAA5555, port: 1, z: 1'b0});
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.z ? zReadData[e.port] : ReadData[e.port];
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL conflict port%0d: got %h expected %h", e.port, act, e.exp);
      end
    end
  endtask

  task automatic test_byte_merge();
    logic [DW-1:0] act;
    sb_t e;
    @(negedge clk);
    idle();
    WriteEnable[1] = 1'b1;
    WriteAddr[1] = 5'd9;
    WriteBE[1] = 4'hF;
    WriteData[1] = 32'h11223344;
    @(negedge clk);
    idle();
    WriteEnable[0] = 1'b1;
    WriteAddr[0] = 5'd9;
    WriteBE[0] = 4'h4;
    WriteData[0] = 32'hFFFFFFFF;
    ReadEnable[0] = 1'b1;
    ReadAddr[0] = 5'd9;
    sb.push_back('{exp: 32'h11FF3344, port: 0, z: 1'b0});
    tick();
    // no-op write: enables high but no byte lanes selected
    @(negedge clk);
    idle();
    WriteEnable = 2'b11;
    WriteAddr[0] = 5'd9;
    WriteAddr[1] = 5'd9;
    WriteBE = '0;
    WriteData[0] = 32'h0;
    WriteData[1] = 32'hFFFFFFFF;
    sb.push_back('{exp: 32'h11FF3344, port: 0, z: 1'b0});
    while (sb.size() > 1) begin
      e = sb.pop_front();
      act = e.z ? zReadData[e.port] : ReadData[e.port];
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL byte_merge port%0d: got %h expected %h", e.port, act, e.exp);
      end
    end
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.z ? zReadData[e.port] : ReadData[e.port];
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL byte_noop port%0d: got %h expected %h", e.port, act, e.exp);
      end
    end
  endtask

  task automatic test_held_addr();
    logic [DW-1:0] act;
    sb_t e;
    @(negedge clk);
    idle();
    ReadEnable[0] = 1'b1;
    ReadAddr[0] = 5'd5;
    sb.push_back('{exp: 32'h0, port: 0, z: 1'b0});
    tick();
    @(negedge clk);
    idle();
    ReadAddr[0] = 5'd9;          // ignored: enable is low
    WriteEnable[1] = 1'b1;
    WriteAddr[1] = 5'd5;
    WriteBE[1] = 4'hF;
    WriteData[1] = 32'hCAFEF00D;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.z ? zReadData[e.port] : ReadData[e.port];
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL held_before port%0d: got %h expected %h", e.port, act, e.exp);
      end
    end
    sb.push_back('{exp: 32'hCAFEF00D, port: 0, z: 1'b0});
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.z ? zReadData[e.port] : ReadData[e.port];
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL held_after port%0d: got %h expected %h", e.port, act, e.exp);
      end
    end
  endtask

  task automatic test_zero_reg();
    logic [DW-1:0] act;
    sb_t e;
    @(negedge clk);
    idle();
    WriteEnable = 2'b11;
    WriteBE = '1;
    WriteData[0] = 32'hFFFFFFFF;
    WriteData[1] = 32'hFFFFFFFF;
    ReadEnable = 2'b11;
    sb.push_back('{exp: 32'h0, port: 0, z: 1'b1});
    sb.push_back('{exp: 32'h0, port: 1, z: 1'b1});
    sb.push_back('{exp: 32'hFFFFFFFF, port: 0, z: 1'b0});
    tick();
    @(negedge clk);
    idle();
    WriteEnable[0] = 1'b1;
    WriteAddr[0] = 5'd1;
    WriteBE[0] = 4'hF;
    WriteData[0] = 32'h0BADF00D;
    ReadEnable[1] = 1'b1;
    ReadAddr[1] = 5'd1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.z ? zReadData[e.port] : ReadData[e.port];
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL zero_word z=%0d port%0d: got %h expected %h", e.z, e.port, act, e.exp);
      end
    end
    sb.push_back('{exp: 32'h0BADF00D, port: 1, z: 1'b1});
    sb.push_back('{exp: 32'h0, port: 0, z: 1'b1});
    tick();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      act = e.z ? zReadData[e.port] : ReadData[e.port];
      n_cmp++;
      if (act !== e.exp) begin
        n_bad++;
        $display("FAIL zero_word_addr1 z=%0d port%0d: got %h expected %h", e.z, e.port, act, e.exp);
      end
    end
  endtask

  // Random back-to-back traffic on a narrow address window against a
  // bench-side memory model (ascending port order = higher port wins).
  task automatic test_back_to_back();
    logic [DW-1:0] model [32];
    logic [AW-1:0] raddr_m [NR];
    logic [DW-1:0] act;
    sb_t e;
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = 32'h0;
    for (int r = 0; r < NR; r++) raddr_m[r] = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      for (int w = 0; w < NW; w++) begin
        WriteEnable[w] = 1'($urandom_range(0, 1));
        WriteAddr[w]   = AW'($urandom_range(0, 7));
        WriteBE[w]     = NB'($urandom_range(0, 15));
        WriteData[w]   = DW'($urandom);
      end
      for (int r = 0; r < NR; r++) begin
        ReadEnable[r] = 1'($urandom_range(0, 1));
        ReadAddr[r]   = AW'($urandom_range(0, 7));
      end
      for (int w = 0; w < NW; w++) begin
        for (int b = 0; b < NB; b++) begin
          if (WriteEnable[w] && WriteBE[w][b]) begin
            model[WriteAddr[w]][8*b +: 8] = WriteData[w][8*b +: 8];
          end
        end
      end
      for (int r = 0; r < NR; r++) begin
        if (ReadEnable[r]) raddr_m[r] = ReadAddr[r];
        sb.push_back('{exp: model[raddr_m[r]], port: r, z: 1'b0});
      end
      tick();
      while (sb.size() > 0) begin
        e = sb.pop_front();
        act = e.z ? zReadData[e.port] : ReadData[e.port];
        n_cmp++;
        if (act !== e.exp) begin
          n_bad++;
          $display("FAIL back_to_back cyc%0d port%0d: got %h expected %h", c, e.port, act, e.exp);
        end
      end
    end
    @(negedge clk);
    idle();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_write_first();
    test_conflict();
    test_byte_merge();
    test_held_addr();
    test_zero_reg();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
